mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM between the core's instruction-fetch
//   port (I) and its load/store port (D). Arbitrates between them and drives RAM
//   byte enables from the access width and address offset. Returns read data to
//   the winning port one cycle later, aligned to bit 0.
//   Sits between RiscVCore (via its stall/handshake wrapper) and the RAM macro.
// PARAMETERS
//   MEM_AW        12  RAM word-address width (RAM = 2**MEM_AW x 32 bit)
//   STARVE_LIMIT  4   consecutive D grants while I is waiting before I is forced in (>=1)
// PORTS
//   clock         in   1       system clock, all state on posedge
//   reset         in   1       synchronous, active-high
//   i_req_valid   in   1       fetch request
//   i_req_addr    in   32      fetch byte address; bits [1:0] ignored
//   i_req_ready   out  1       fetch accepted this cycle
//   i_resp_valid  out  1       fetch data valid (one cycle)
//   i_resp_data   out  32      fetched word
//   d_req_valid   in   1       load/store request
//   d_req_write   in   1       1 = store, 0 = load
//   d_req_width   in   2       0 = byte, 1 = half, 2 = word, 3 = illegal
//   d_req_addr    in   32      byte address
//   d_req_wdata   in   32      store data, right-aligned
//   d_req_ready   out  1       load/store accepted this cycle
//   d_resp_valid  out  1       load data / store ack valid (one cycle)
//   d_resp_data   out  32      load data, right-aligned, zero-extended; 0 for stores/errors
//   d_resp_err    out  1       qualifies d_resp_valid: misaligned or illegal width
//   mem_en        out  1       RAM access strobe
//   mem_we        out  1       RAM write
//   mem_be        out  4       RAM byte enables
//   mem_addr      out  MEM_AW  RAM word address = addr[MEM_AW+1:2]; upper bits ignored (alias)
//   mem_wdata     out  32      RAM write data, lane-replicated
//   mem_rdata     in   32      RAM read data, valid the cycle after mem_en && !mem_we
// BEHAVIOUR
//   Grant (combinational, at most one transfer per cycle):
//   - grant_d = d_req_valid && !(i_req_valid && starve_cnt == STARVE_LIMIT).
//   - grant_i = i_req_valid && !grant_d.
//   - ready = grant; a transfer occurs when valid && ready.
//   - Ready is asserted without waiting on valid; there is no backpressure on responses.
//   Starvation counter, 0..STARVE_LIMIT, saturating:
//   - +1 on a D transfer while i_req_valid is high.
//   - Cleared on an I transfer, or whenever i_req_valid is low.
//   RAM access (same cycle as the transfer):
//   - mem_en = 1; mem_addr from the granted address.
//   - I transfer: mem_we = 0, mem_be = 4'b1111.
//   - D transfer: mem_we = d_req_write; off = d_req_addr[1:0].
//       byte: be = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
//       half: be = 4'b0011 << off; wdata = {2{wdata[15:0]}}.
//       word: be = 4'b1111; wdata passed through.
//   - Faults (illegal width, half with off[0]=1, word with off!=0):
//       request is still consumed (ready = 1, counts as a D grant for starvation);
//       mem_en = 0.
//   - When mem_en = 0: mem_we, mem_be, mem_addr, mem_wdata are all 0.
//   Response (fixed latency 1; registered owner, offset, width, write and fault tag):
//   - Cycle after an I transfer: i_resp_valid = 1, i_resp_data = mem_rdata.
//   - Cycle after a D load: d_resp_valid = 1.
//       d_resp_data = (mem_rdata >> 8*off) masked to 8/16/32 bits.
//       Zero-extended; the core performs sign extension.
//   - Cycle after a D store: d_resp_valid = 1, d_resp_data = 0.
//   - Cycle after a fault: d_resp_valid = 1, d_resp_err = 1, d_resp_data = 0, no RAM side effect.
//   - Outside response cycles, all resp outputs are 0.
//   - Back-to-back transfers are fully pipelined: the cycle-N+1 response and the
//     cycle-N+1 transfer coexist.
//   Reset (synchronous):
//   - While reset is high: ready outputs 0, mem_en 0, all resp outputs 0; starve_cnt and response tags cleared.
//   - Any response due in the cycle after reset is dropped.
//   - The first transfer can occur in the first cycle with reset low.
// TESTING
//   1 I only, addr 0x10, RAM[4]=0xDEADBEEF -> cycle N: mem_addr=4, be=F; N+1: i_resp_data=0xDEADBEEF.
//   2 I and D valid together, STARVE_LIMIT=4, D valid every cycle:
//     D granted 4 cycles, I granted in cycle 5, counter cleared, D again in cycle 6.
//   3 sb addr 0x23 data 0x000000AB -> mem_addr=8, be=4'b1000, wdata=0xABABABAB;
//     lbu 0x23 -> d_resp_data=0x000000AB.
//   4 sh addr 0x102 data 0x1234, then lh 0x102
//     -> be=4'b1100, wdata=0x12341234; d_resp_data=0x00001234.
//   5 lw addr 0x6, lh addr 0x3, width=3 -> each: ready=1, mem_en=0,
//     next cycle d_resp_valid=1, d_resp_err=1, data 0; RAM unchanged.
//   6 assert reset the cycle after a load transfer -> no d_resp_valid,
//     ready=0 during reset, starve_cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a single-port synchronous RAM between the instruction-fetch
//            and load/store ports, with starvation guard and byte-lane steering.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_AW       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [31:0]       i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [31:0]       i_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [1:0]        d_req_width,
    input  logic [31:0]       d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [31:0]       d_resp_data,
    output logic              d_resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_i_pend;
    logic               r_d_pend;
    logic               r_d_write;
    logic               r_d_fault;
    logic [1:0]         r_d_off;
    logic [1:0]         r_d_width;

    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_fault;
    logic [1:0]         w_off;
    logic [31:0]        w_shift;
    logic [31:0]        w_load;
    logic               w_unused;

    // Address bits outside the RAM window alias and are intentionally dropped.
    assign w_unused = ^{i_req_addr[31:MEM_AW+2], i_req_addr[1:0], d_req_addr[31:MEM_AW+2]};

    assign w_off   = d_req_addr[1:0];
    assign w_fault = (d_req_width == 2'd3)
                   || ((d_req_width == 2'd1) && w_off[0])
                   || ((d_req_width == 2'd2) && (w_off != 2'd0));

    assign w_grant_d = !reset && d_req_valid
                     && !(i_req_valid && (r_starve_cnt == c_CNT_W'(STARVE_LIMIT)));
    assign w_grant_i = !reset && i_req_valid && !w_grant_d;

    assign i_req_ready = w_grant_i;
    assign d_req_ready = w_grant_d;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_grant_i) begin
            mem_en   = 1'b1;
            mem_be   = 4'b1111;
            mem_addr = i_req_addr[MEM_AW+1:2];
        end else if (w_grant_d && !w_fault) begin
            mem_en   = 1'b1;
            mem_we   = d_req_write;
            mem_addr = d_req_addr[MEM_AW+1:2];
            case (d_req_width)
                2'd0: begin
                    mem_be    = 4'b0001 << w_off;
                    mem_wdata = {4{d_req_wdata[7:0]}};
                end
                2'd1: begin
                    mem_be    = 4'b0011 << w_off;
                    mem_wdata = {2{d_req_wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = d_req_wdata;
                end
            endcase
        end
    end

    // Starvation counter saturates at the limit; any idle I cycle clears it.
    always_ff @(posedge clock) begin
        if (reset || !i_req_valid || w_grant_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && (r_starve_cnt != c_CNT_W'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_i_pend  <= 1'b0;
            r_d_pend  <= 1'b0;
            r_d_write <= 1'b0;
            r_d_fault <= 1'b0;
            r_d_off   <= 2'd0;
            r_d_width <= 2'd0;
        end else begin
            r_i_pend <= w_grant_i;
            r_d_pend <= w_grant_d;
            if (w_grant_d) begin
                r_d_write <= d_req_write;
                r_d_fault <= w_fault;
                r_d_off   <= w_off;
                r_d_width <= d_req_width;
            end
        end
    end

    assign w_shift = mem_rdata >> {r_d_off, 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_d_width)
            2'd0:    w_load = {24'h0, w_shift[7:0]};
            2'd1:    w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // Responses are gated by reset so a response due during reset is dropped.
    assign i_resp_valid = r_i_pend && !reset;
    assign i_resp_data  = i_resp_valid ? mem_rdata : 32'h0;
    assign d_resp_valid = r_d_pend && !reset;
    assign d_resp_err   = d_resp_valid && r_d_fault;
    assign d_resp_data  = (d_resp_valid && !r_d_write && !r_d_fault) ? w_load : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a RAM model and a
//            response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MEM_AW = 12;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              i_req_valid = 1'b0;
    logic [31:0]       i_req_addr = 32'h0;
    logic              i_req_ready;
    logic              i_resp_valid;
    logic [31:0]       i_resp_data;
    logic              d_req_valid = 1'b0;
    logic              d_req_write = 1'b0;
    logic [1:0]        d_req_width = 2'd0;
    logic [31:0]       d_req_addr = 32'h0;
    logic [31:0]       d_req_wdata = 32'h0;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [31:0]       d_resp_data;
    logic              d_resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [31:0] ram [0:(1<<MEM_AW)-1];

    mem_port_arbiter #(.MEM_AW(MEM_AW), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_width(d_req_width),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model; known contents are restored whenever reset is high.
    always @(posedge clock) begin
        if (reset) begin
            ram[0]     <= 32'h01020304;
            ram[2]     <= 32'hCAFEF00D;
            ram[4]     <= 32'hDEADBEEF;
            ram[8]     <= 32'h11223344;
            ram[12'h40] <= 32'h00000000;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Scoreboard: each queued entry must appear exactly in its due cycle.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            n_checks++;
            if ({i_resp_valid, d_resp_valid, d_resp_err} !== {!e.is_d, e.is_d, e.err}) begin
                n_fail++;
                $display("FAIL resp_flags cyc=%0d: got i_v=%b d_v=%b err=%b expected i_v=%b d_v=%b err=%b",
                         cyc, i_resp_valid, d_resp_valid, d_resp_err, !e.is_d, e.is_d, e.err);
            end
            n_checks++;
            if ({i_resp_data, d_resp_data} !== (e.is_d ? {32'h0, e.data} : {e.data, 32'h0})) begin
                n_fail++;
                $display("FAIL resp_data cyc=%0d: got i=%h d=%h expected %s data %h",
                         cyc, i_resp_data, d_resp_data, e.is_d ? "d" : "i", e.data);
            end
        end else begin
            n_checks++;
            if ({i_resp_valid, d_resp_valid, d_resp_err, i_resp_data, d_resp_data} !== 67'h0) begin
                n_fail++;
                $display("FAIL resp_idle cyc=%0d: got i_v=%b d_v=%b err=%b i=%h d=%h expected all zero",
                         cyc, i_resp_valid, d_resp_valid, d_resp_err, i_resp_data, d_resp_data);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_i(input logic [31:0] a);
        i_req_valid = 1'b1;
        i_req_addr  = a;
    endtask

    task automatic drive_d(input logic wr, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd);
        d_req_valid = 1'b1;
        d_req_write = wr;
        d_req_width = w;
        d_req_addr  = a;
        d_req_wdata = wd;
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        d_req_write = 1'b0;
        d_req_wdata = 32'h0;
    endtask

    task automatic push(input bit is_d, input logic [31:0] data, input bit err);
        q.push_back('{is_d: is_d, data: data, err: err, due: cyc + 1});
    endtask

    task automatic test_reset();
        drive_i(32'h10);
        drive_d(1'b1, 2'd2, 32'h10, 32'h55);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clock);
            n_checks++;
            if ({i_req_ready, d_req_ready, mem_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_ready: got i_rdy=%b d_rdy=%b en=%b expected 000",
                         i_req_ready, d_req_ready, mem_en);
            end
        end
    endtask

    task automatic test_ifetch();
        logic [31:0] addrs [2];
        addrs[0] = 32'h00000010;
        addrs[1] = 32'h80010013;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            reset = 1'b0;
            idle();
            drive_i(addrs[k]);
            @(negedge clock);
            n_checks++;
            if ({i_req_ready, d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata}
                !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'd4, 32'h0}) begin
                n_fail++;
                $display("FAIL ifetch_req: got rdy=%b/%b en=%b we=%b be=%h addr=%h wd=%h expected 1/0 1 0 f 004 0",
                         i_req_ready, d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
            end
            push(1'b0, 32'hDEADBEEF, 1'b0);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_starvation();
        bit exp_d;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            drive_i(32'h10);
            drive_d(1'b0, 2'd2, 32'h10, 32'h0);
            @(negedge clock);
            exp_d = (k != 4) && (k != 9);
            n_checks++;
            if ({d_req_ready, i_req_ready, mem_en, mem_addr} !== {exp_d, !exp_d, 1'b1, 12'd4}) begin
                n_fail++;
                $display("FAIL starve_grant k=%0d: got d_rdy=%b i_rdy=%b en=%b addr=%h expected d_rdy=%b i_rdy=%b en=1 addr=004",
                         k, d_req_ready, i_req_ready, mem_en, mem_addr, exp_d, !exp_d);
            end
            push(exp_d, 32'hDEADBEEF, 1'b0);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_store_byte();
        next_cycle();
        drive_d(1'b1, 2'd0, 32'h23, 32'h000000AB);
        @(negedge clock);
        n_checks++;
        if ({d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata}
            !== {1'b1, 1'b1, 1'b1, 4'b1000, 12'd8, 32'hABABABAB}) begin
            n_fail++;
            $display("FAIL sb_req: got rdy=%b en=%b we=%b be=%b addr=%h wd=%h expected 1 1 1 1000 008 ababab",
                     d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        push(1'b1, 32'h0, 1'b0);
        next_cycle();
        drive_d(1'b0, 2'd0, 32'h23, 32'h0);
        @(negedge clock);
        n_checks++;
        if ({d_req_ready, mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'b1000, 12'd8}) begin
            n_fail++;
            $display("FAIL lbu_req: got rdy=%b en=%b we=%b be=%b addr=%h expected 1 1 0 1000 008",
                     d_req_ready, mem_en, mem_we, mem_be, mem_addr);
        end
        push(1'b1, 32'h000000AB, 1'b0);
    endtask

    // Word 8 now holds 0xAB223344; loads of every legal lane, back to back.
    task automatic test_load_lanes();
        logic [1:0]  wid [7];
        logic [31:0] adr [7];
        logic [31:0] dat [7];
        logic [3:0]  ben [7];
        wid = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        adr = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h20, 32'h22, 32'h20};
        dat = '{32'h44, 32'h33, 32'h22, 32'hAB, 32'h3344, 32'hAB22, 32'hAB223344};
        ben = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            drive_d(1'b0, wid[k], adr[k], 32'h0);
            @(negedge clock);
            n_checks++;
            if ({d_req_ready, mem_en, mem_be, mem_addr} !== {1'b1, 1'b1, ben[k], 12'd8}) begin
                n_fail++;
                $display("FAIL lane_req k=%0d: got rdy=%b en=%b be=%b addr=%h expected 1 1 %b 008",
                         k, d_req_ready, mem_en, mem_be, mem_addr, ben[k]);
            end
            push(1'b1, dat[k], 1'b0);
        end
    endtask

    task automatic test_half();
        next_cycle();
        drive_d(1'b1, 2'd1, 32'h102, 32'hFFFF1234);
        @(negedge clock);
        n_checks++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 12'h40, 32'h12341234}) begin
            n_fail++;
            $display("FAIL sh_req: got en=%b we=%b be=%b addr=%h wd=%h expected 1 1 1100 040 12341234",
                     mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        push(1'b1, 32'h0, 1'b0);
        next_cycle();
        drive_d(1'b0, 2'd1, 32'h102, 32'h0);
        @(negedge clock);
        push(1'b1, 32'h00001234, 1'b0);
    endtask

    task automatic test_faults();
        logic        wr  [3];
        logic [1:0]  wid [3];
        logic [31:0] adr [3];
        wr  = '{1'b0, 1'b1, 1'b1};
        wid = '{2'd2, 2'd1, 2'd3};
        adr = '{32'h6, 32'h3, 32'h8};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive_d(wr[k], wid[k], adr[k], 32'hFFFFFFFF);
            @(negedge clock);
            n_checks++;
            if ({d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0}) begin
                n_fail++;
                $display("FAIL fault_req k=%0d: got rdy=%b en=%b we=%b be=%b addr=%h wd=%h expected 1 then all zero",
                         k, d_req_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
            end
            push(1'b1, 32'h0, 1'b1);
        end
        next_cycle();
        drive_d(1'b0, 2'd2, 32'h0, 32'h0);
        @(negedge clock);
        push(1'b1, 32'h01020304, 1'b0);
        next_cycle();
        drive_d(1'b0, 2'd2, 32'h8, 32'h0);
        @(negedge clock);
        push(1'b1, 32'hCAFEF00D, 1'b0);
        next_cycle();
        idle();
    endtask

    task automatic test_reset_drop();
        bit exp_d;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive_i(32'h10);
            drive_d(1'b0, 2'd2, 32'h10, 32'h0);
            @(negedge clock);
            if (k < 2) push(1'b1, 32'hDEADBEEF, 1'b0);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({i_req_ready, d_req_ready, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got i_rdy=%b d_rdy=%b en=%b expected 000",
                     i_req_ready, d_req_ready, mem_en);
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            reset = 1'b0;
            @(negedge clock);
            exp_d = (k != 4);
            n_checks++;
            if ({d_req_ready, i_req_ready} !== {exp_d, !exp_d}) begin
                n_fail++;
                $display("FAIL post_reset_grant k=%0d: got d_rdy=%b i_rdy=%b expected d_rdy=%b i_rdy=%b",
                         k, d_req_ready, i_req_ready, exp_d, !exp_d);
            end
            push(exp_d, 32'hDEADBEEF, 1'b0);
        end
        next_cycle();
        idle();
        repeat (3) next_cycle();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_starvation();
        test_store_byte();
        test_load_lanes();
        test_half();
        test_faults();
        test_reset_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
